// File: rtl/itu656_pkg.sv
// itu656_pkg: BT.656 timing constants, code bytes and helper functions.
// Shared by itu656_timing and itu656_encoder.
package itu656_pkg;

  localparam int NTSC_H_TOTAL = 1716;
  localparam int PAL_H_TOTAL  = 1728;
  localparam int H_ACTIVE_STD = 1440;
  localparam int NTSC_LINES   = 525;
  localparam int PAL_LINES    = 625;

  localparam int NTSC_F_CLR  = 4;
  localparam int NTSC_F_SET  = 266;
  localparam int NTSC_V_CLR0 = 20;
  localparam int NTSC_V_SET0 = 264;
  localparam int NTSC_V_CLR1 = 283;

  localparam int PAL_F_CLR  = 1;
  localparam int PAL_F_SET  = 313;
  localparam int PAL_V_CLR0 = 23;
  localparam int PAL_V_SET0 = 311;
  localparam int PAL_V_CLR1 = 336;

  localparam logic [7:0] PRE_FF  = 8'hFF;
  localparam logic [7:0] PRE_00  = 8'h00;
  localparam logic [7:0] BLANK_C = 8'h80;
  localparam logic [7:0] BLANK_Y = 8'h10;

  typedef enum logic [1:0] {
    REG_EAV,
    REG_BLANK,
    REG_SAV,
    REG_ACT
  } region_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  function automatic logic [7:0] xy_code(
    input logic f,
    input logic v,
    input logic h
  );
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] preamble(
    input logic [1:0] idx,
    input logic [7:0] xy
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = PRE_FF;
      2'd3:    b = xy;
      default: b = PRE_00;
    endcase
    return b;
  endfunction

  // 00 and FF are reserved for timing reference codes
  function automatic logic [7:0] clamp656(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b == 8'h00) r = 8'h01;
    else if (b == 8'hFF) r = 8'hFE;
    return r;
  endfunction

  function automatic ycc_t bar_color(input logic [2:0] idx);
    ycc_t c;
    unique case (idx)
      3'd0: c = '{8'd180, 8'd128, 8'd128};
      3'd1: c = '{8'd162, 8'd44,  8'd142};
      3'd2: c = '{8'd131, 8'd156, 8'd44};
      3'd3: c = '{8'd112, 8'd72,  8'd58};
      3'd4: c = '{8'd84,  8'd184, 8'd198};
      3'd5: c = '{8'd65,  8'd100, 8'd212};
      3'd6: c = '{8'd35,  8'd212, 8'd114};
      3'd7: c = '{8'd16,  8'd128, 8'd128};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/itu656_timing.sv
// itu656_timing: byte/line counters with F, V and line-region decode.
// Byte positions 0..3 are EAV, the four before active video are SAV.
module itu656_timing
  import itu656_pkg::*;
#(
  parameter  int H_TOTAL    = NTSC_H_TOTAL,
  parameter  int H_ACTIVE   = H_ACTIVE_STD,
  parameter  int LINES      = NTSC_LINES,
  parameter  int F_CLR_LINE = NTSC_F_CLR,
  parameter  int F_SET_LINE = NTSC_F_SET,
  parameter  int V_CLR0     = NTSC_V_CLR0,
  parameter  int V_SET0     = NTSC_V_SET0,
  parameter  int V_CLR1     = NTSC_V_CLR1,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int LW         = $clog2(LINES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [LW-1:0] line,
  output logic          f,
  output logic          v,
  output region_t       region,
  output logic [1:0]    pre_idx,
  output logic [HW-1:0] act_idx
);

  localparam int SAV0 = H_TOTAL - H_ACTIVE - 4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      line <= LW'(1);
    end else if (hcnt == HW'(H_TOTAL - 1)) begin
      hcnt <= '0;
      line <= (line == LW'(LINES)) ? LW'(1) : line + LW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign f = (line < LW'(F_CLR_LINE)) || (line >= LW'(F_SET_LINE));
  assign v = (line < LW'(V_CLR0)) ||
             ((line >= LW'(V_SET0)) && (line < LW'(V_CLR1)));

  always_comb begin
    region = REG_ACT;
    if (hcnt < HW'(4)) region = REG_EAV;
    else if (hcnt < HW'(SAV0)) region = REG_BLANK;
    else if (hcnt < HW'(SAV0 + 4)) region = REG_SAV;
  end

  assign pre_idx = (region == REG_EAV) ? hcnt[1:0]
                                       : 2'(hcnt - HW'(SAV0));
  assign act_idx = hcnt - HW'(H_TOTAL - H_ACTIVE);

endmodule

// File: rtl/itu656_encoder.sv
// itu656_encoder: BT.656 byte serialiser with pixel pull, clamp and flags.
// Define ITU656_COLORBAR_EN to add iBar_En and the colour-bar source.
module itu656_encoder
  import itu656_pkg::*;
#(
  parameter  int H_TOTAL    = NTSC_H_TOTAL,
  parameter  int H_ACTIVE   = H_ACTIVE_STD,
  parameter  int LINES      = NTSC_LINES,
  parameter  int F_CLR_LINE = NTSC_F_CLR,
  parameter  int F_SET_LINE = NTSC_F_SET,
  parameter  int V_CLR0     = NTSC_V_CLR0,
  parameter  int V_SET0     = NTSC_V_SET0,
  parameter  int V_CLR1     = NTSC_V_CLR1,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int LW         = $clog2(LINES + 1)
) (
  input  logic        iCLK_27,
  input  logic        iRST_N,
`ifdef ITU656_COLORBAR_EN
  input  logic        iBar_En,
`endif
  input  logic [15:0] iYCbCr,
  output logic        oRequest,
  output logic [7:0]  oTD_DATA,
  output logic        oH,
  output logic        oV,
  output logic        oF,
  output logic        oSOF
);

  localparam int   A0      = H_TOTAL - H_ACTIVE;
  localparam logic REQ_PAR = 1'((A0 - 2) % 2);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] act_idx;
  logic [LW-1:0] line;
  logic          f;
  logic          v;
  region_t       region;
  logic [1:0]    pre_idx;
  logic          bar_on;
  logic [7:0]    y_hold;
  logic [7:0]    src_byte;
  logic [7:0]    byte_next;
  logic          h_next;
  logic          req_next;
  logic          c_slot;

  itu656_timing #(
    .H_TOTAL   (H_TOTAL),
    .H_ACTIVE  (H_ACTIVE),
    .LINES     (LINES),
    .F_CLR_LINE(F_CLR_LINE),
    .F_SET_LINE(F_SET_LINE),
    .V_CLR0    (V_CLR0),
    .V_SET0    (V_SET0),
    .V_CLR1    (V_CLR1)
  ) u_timing (
    .clk    (iCLK_27),
    .rst_n  (iRST_N),
    .hcnt   (hcnt),
    .line   (line),
    .f      (f),
    .v      (v),
    .region (region),
    .pre_idx(pre_idx),
    .act_idx(act_idx)
  );

`ifdef ITU656_COLORBAR_EN
  logic       bar_q;
  ycc_t       bar;
  logic [7:0] bar_byte;

  always_ff @(posedge iCLK_27) begin
    if (!iRST_N) bar_q <= 1'b0;
    else if (hcnt == '0) bar_q <= iBar_En;
  end

  assign bar_on = bar_q;
  assign bar    = bar_color(3'(act_idx / HW'(H_ACTIVE / 8)));

  always_comb begin
    unique case (act_idx[1:0])
      2'd0:    bar_byte = bar.cb;
      2'd2:    bar_byte = bar.cr;
      default: bar_byte = bar.y;
    endcase
  end
`else
  logic unused_idx;
  assign bar_on     = 1'b0;
  assign unused_idx = ^act_idx[HW-1:1];
`endif

  assign c_slot = (region == REG_ACT) && !act_idx[0];

  // request lands two bytes ahead so the word arrives for its C slot
  assign req_next = !v && !bar_on &&
                    (hcnt >= HW'(A0 - 2)) &&
                    (hcnt <= HW'(H_TOTAL - 4)) &&
                    (hcnt[0] == REQ_PAR);

  always_ff @(posedge iCLK_27) begin
    if (!iRST_N) y_hold <= '0;
    else if (c_slot && !v && !bar_on) y_hold <= iYCbCr[7:0];
  end

  always_comb begin
    src_byte = clamp656(act_idx[0] ? y_hold : iYCbCr[15:8]);
`ifdef ITU656_COLORBAR_EN
    if (bar_on) src_byte = bar_byte;
`endif
  end

  always_comb begin
    byte_next = BLANK_C;
    h_next    = 1'b0;
    unique case (region)
      REG_EAV: begin
        byte_next = preamble(pre_idx, xy_code(f, v, 1'b1));
        h_next    = 1'b1;
      end
      REG_BLANK: begin
        byte_next = hcnt[0] ? BLANK_Y : BLANK_C;
        h_next    = 1'b1;
      end
      REG_SAV: begin
        byte_next = preamble(pre_idx, xy_code(f, v, 1'b0));
      end
      default: begin
        if (v) byte_next = act_idx[0] ? BLANK_Y : BLANK_C;
        else byte_next = src_byte;
      end
    endcase
  end

  always_ff @(posedge iCLK_27) begin
    if (!iRST_N) begin
      oTD_DATA <= BLANK_C;
      oRequest <= 1'b0;
      oH       <= 1'b0;
      oV       <= 1'b0;
      oF       <= 1'b0;
      oSOF     <= 1'b0;
    end else begin
      oTD_DATA <= byte_next;
      oRequest <= req_next;
      oH       <= h_next;
      oV       <= v;
      oF       <= f;
      oSOF     <= (hcnt == '0) && (line == LW'(1));
    end
  end

endmodule

// File: tb/tb_itu656_encoder.sv
// tb_itu656_encoder: scoreboard bench on a shrunken 40x12 raster.
// Expected bytes/flags are queued up front; a negedge monitor pops them.
module tb_itu656_encoder;

  localparam int HT = 40;
  localparam int HA = 24;
  localparam int NL = 12;
  localparam int A0 = HT - HA;
  localparam int M_RAMP  = 0;
  localparam int M_CONST = 1;
  localparam int M_BAR   = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       h;
    logic       v;
    logic       f;
    logic       sof;
    logic       req;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ycbcr = 16'h0000;
  logic        req;
  logic [7:0]  td;
  logic        h, v, f, sof;
`ifdef ITU656_COLORBAR_EN
  logic        bar_en = 1'b0;
`endif

  // hand-derived per-line F, V and XY codes for this raster
  bit         lf   [1:NL] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  bit         lv   [1:NL] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
  logic [7:0] leav [1:NL] = '{8'hF1, 8'hB6, 8'h9D, 8'h9D, 8'h9D, 8'hB6,
                              8'hF1, 8'hF1, 8'hDA, 8'hDA, 8'hDA, 8'hDA};
  logic [7:0] lsav [1:NL] = '{8'hEC, 8'hAB, 8'h80, 8'h80, 8'h80, 8'hAB,
                              8'hEC, 8'hEC, 8'hC7, 8'hC7, 8'hC7, 8'hC7};
  logic [7:0] bar_b [0:HA-1] = '{
    8'h80, 8'hB4, 8'h80, 8'hA2, 8'h2C, 8'hA2, 8'h2C, 8'h83,
    8'h9C, 8'h70, 8'h3A, 8'h70, 8'hB8, 8'h54, 8'hC6, 8'h41,
    8'h64, 8'h41, 8'h72, 8'h23, 8'hD4, 8'h10, 8'h80, 8'h10};

  exp_t exp_q[$];
  exp_t e_got, e_exp;
  int   vecs = 0;
  int   miss = 0;
  int   nprint = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   last_sof = 0;
  int   sof_n = 0;
  int   req_cnt = 0;
  int   frame_no = 0;
  int   k = 0;

  always #5 clk = ~clk;

  itu656_encoder #(
    .H_TOTAL   (HT),
    .H_ACTIVE  (HA),
    .LINES     (NL),
    .F_CLR_LINE(2),
    .F_SET_LINE(7),
    .V_CLR0    (3),
    .V_SET0    (6),
    .V_CLR1    (9)
  ) dut (
    .iCLK_27 (clk),
    .iRST_N  (rst_n),
`ifdef ITU656_COLORBAR_EN
    .iBar_En (bar_en),
`endif
    .iYCbCr  (ycbcr),
    .oRequest(req),
    .oTD_DATA(td),
    .oH      (h),
    .oV      (v),
    .oF      (f),
    .oSOF    (sof)
  );

  task automatic push_line(input int ln, input int mode, input int last);
    exp_t e;
    int   a;
    for (int n = 0; n <= last; n++) begin
      a     = n - A0;
      e.h   = (n < A0 - 4);
      e.v   = lv[ln];
      e.f   = lf[ln];
      e.sof = (ln == 1) && (n == 0);
      e.req = !lv[ln] && (mode != M_BAR) &&
              (n >= A0 - 2) && (n <= HT - 4) && (n % 2 == 0);
      if (n == 0 || n == A0 - 4) e.d = 8'hFF;
      else if (n == 3) e.d = leav[ln];
      else if (n == A0 - 1) e.d = lsav[ln];
      else if (n < 4 || (n >= A0 - 4 && n < A0)) e.d = 8'h00;
      else if (n < A0 || lv[ln]) e.d = (n % 2 == 0) ? 8'h80 : 8'h10;
      else if (mode == M_RAMP)
        e.d = (a % 2 == 0) ? 8'(8'h40 + a / 2) : 8'(8'h20 + a / 2);
      else if (mode == M_CONST) e.d = (a % 2 == 0) ? 8'hFE : 8'h01;
      else e.d = bar_b[a];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_rst();
    exp_t e;
    e = '{d: 8'h80, h: 1'b0, v: 1'b0, f: 1'b0, sof: 1'b0, req: 1'b0};
    exp_q.push_back(e);
  endtask

  // pixel source: answers each request with word k of the current line
  always @(negedge clk) begin
    if (sof) frame_no++;
    if (h) k = 0;
    else if (req) begin
      if (frame_no == 2) ycbcr = 16'hFF00;
      else ycbcr = {8'(8'h40 + k), 8'(8'h20 + k)};
      k++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      e_got = '{d: td, h: h, v: v, f: f, sof: sof, req: req};
      vecs++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL underrun cyc %0d: got %h, required nothing",
                 cyc, td);
      end else begin
        e_exp = exp_q.pop_front();
        if (e_got !== e_exp) begin
          miss++;
          if (nprint < 20)
            $display("FAIL byte cyc %0d: got d=%h hvfsr=%b%b%b%b%b, required d=%h hvfsr=%b%b%b%b%b",
                     cyc, e_got.d, e_got.h, e_got.v, e_got.f, e_got.sof,
                     e_got.req, e_exp.d, e_exp.h, e_exp.v, e_exp.f,
                     e_exp.sof, e_exp.req);
          nprint++;
        end
      end
      if (sof) begin
        sof_n++;
        if (sof_n == 2 || sof_n == 3) begin
          vecs += 2;
          if (cyc - last_sof != 480) begin
            miss++;
            $display("FAIL frame period: got %0d, required 480",
                     cyc - last_sof);
          end
          if (req_cnt != 84) begin
            miss++;
            $display("FAIL frame requests: got %0d, required 84",
                     req_cnt);
          end
        end
        last_sof = cyc;
        req_cnt  = 0;
      end
      if (req) req_cnt++;
      cyc++;
    end
  end

  initial begin
    int  seen;
    bit  done;
    repeat (2) @(posedge clk);
    #1;
    push_rst();
    push_rst();
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int ln = 1; ln <= NL; ln++) push_line(ln, M_RAMP, HT - 1);
    for (int ln = 1; ln <= NL; ln++) push_line(ln, M_CONST, HT - 1);
    push_line(1, M_RAMP, HT - 1);
    push_line(2, M_RAMP, HT - 1);
    push_line(3, M_RAMP, A0 + 4);
    push_rst();
    push_line(1, M_RAMP, HT - 1);
    push_line(2, M_RAMP, HT - 1);
`ifdef ITU656_COLORBAR_EN
    push_line(3, M_BAR, HT - 1);
`else
    push_line(3, M_RAMP, HT - 1);
`endif

    seen = 0;
    for (int i = 0; i < 3000 && seen < 3; i++) begin
      @(negedge clk);
      if (sof) seen++;
    end
    if (seen < 3) begin
      miss++;
      $display("FAIL sof wait: got %0d pulses, required 3", seen);
    end else begin
      // reset lands while line 3 byte 20 (active a=4) is on the bus
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
`ifdef ITU656_COLORBAR_EN
      bar_en = 1'b1;
`endif
    end

    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    mon_en = 1'b0;
    if (!done) begin
      miss++;
      $display("FAIL drain: got %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
